alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, clocked successor to the switch-driven 32-bit ALU.
- Operands A and B and the opcode are loaded into internal registers over one shared data bus using load strobes.
- A start strobe launches the operation. Results and status flags are registered.
- Adds shifts, signed compare, status flags, and an iterative shift-add unsigned multiply with a busy/done handshake.
- Sits between the board switch/bus interface and the display/output mux of the term CPU project.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, at least 8.
- SHW, $clog2(WIDTH), shift-amount field width taken from A[SHW-1:0].

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  WIDTH  shared load bus.
- ld_a  in  1  capture data_in into A.
- ld_b  in  1  capture data_in into B.
- ld_op  in  1  capture data_in[3:0] into OP.
- start  in  1  launch the operation held in OP on A and B.
- out_sel  in  2  output view select.
- data_out  out  WIDTH  selected view; combinational mux of registers only.
- busy  out  1  multiply in progress.
- done  out  1  one-cycle pulse: result and flags updated.

Behaviour:
- Reset: A, B, OP, RLO, RHI, FLAGS, bit counter and state all cleared to 0; state = IDLE; busy = 0; done = 0; data_out = 0 (out_sel = 0).
- Reset mid-multiply aborts the multiply. RLO, RHI and FLAGS are cleared and no done pulse is issued.
- Loads are accepted only in IDLE; they are ignored while busy. Several ld_* strobes may be asserted in the same cycle and each captures its field.
- start with a load in the same cycle: the load takes effect, but the operation uses the register values held before that edge.
- start while busy is ignored.
- Opcodes:
  - 0 AND; 1 OR; 2 XOR; 3 NOR.
  - 4 ADD; 5 SUB (A-B).
  - 6 SLT: signed; result is 1 if A<B, else 0.
  - 7 SLL: B << A[SHW-1:0]. 8 SRL: B >> A[SHW-1:0]. 9 SRA: arithmetic B >> A[SHW-1:0].
  - 10 MUL: unsigned, 2*WIDTH-bit product.
  - 11-15 illegal.
- Single-cycle ops (0-9, illegal): at the edge sampling start in IDLE, RLO takes the result, RHI is cleared and FLAGS are updated. done = 1 for exactly the next cycle; busy stays 0.
- MUL state machine:
  - IDLE --start & OP=10--> MUL. Operands are snapshotted, the accumulator and counter are cleared, busy = 1.
  - MUL: one shift-add iteration per clock for WIDTH clocks.
  - After the WIDTH-th iteration edge: return to IDLE, {RHI,RLO} = product, FLAGS updated, busy = 0, done = 1 for one cycle.
  - done therefore rises WIDTH cycles after the start edge; busy is high for exactly WIDTH cycles.
- FLAGS[4:0] = {E,V,C,N,Z}:
  - Z: result is zero. For MUL, the full 2W product is zero.
  - N: RLO[WIDTH-1]. For MUL, N = 0.
  - C (ADD): carry out of bit WIDTH-1.
  - C (SUB): borrow, i.e. A<B unsigned.
  - C (MUL): RHI != 0.
  - C for all other ops: 0.
  - V: signed overflow for ADD/SUB only; 0 for all other ops.
  - E: illegal opcode. Result = 0, Z = 1, all other flags = 0.
- Arithmetic wraps modulo 2^WIDTH.
- A shift amount of 0 passes B through unchanged.
- SRA replicates B[WIDTH-1].
- out_sel views:
  - 0: RLO.
  - 1: RHI.
  - 2: {zero-extend, FLAGS}.
  - 3: {zero-extend, state (1 bit), OP}.
- Results persist in RLO/RHI/FLAGS until the next completed operation or reset.

Test Plan:
- AND: A=0x0001FFFF, B=0x0001000F, OP=0, start -> next cycle: done=1, RLO=0x0001000F, FLAGS=0, busy never 1.
- ADD overflow: A=0x7FFFFFFF, B=0x00000001, OP=4 -> RLO=0x80000000, FLAGS=0x0A (V=1, N=1, C=0, Z=0).
- SUB with borrow: A=0x0001FFFF, B=0xFFF1000F, OP=5 -> RLO=0x0010FFF0, C=1, V=0, N=0. Then SLT with A=0xFFFFFFFF, B=1, OP=6 -> RLO=1.
- Shifts with B=0xFFFFFFFF, A=4:
  - SLL -> 0xFFFFFFF0.
  - SRL -> 0x0FFFFFFF.
  - SRA -> 0xFFFFFFFF.
  - A=0 -> B unchanged.
- MUL: A=B=0xFFFFFFFF, OP=10, start -> busy high 32 cycles, done in cycle 32 after the start edge, RHI=0xFFFFFFFE, RLO=0x00000001, C=1. ld_a pulsed mid-run is ignored; start with an ld_b in the same cycle uses the old B.
- Reset and illegal opcode:
  - Assert rst at cycle 10 of a MUL -> next cycle busy=0, no done pulse, RLO=RHI=FLAGS=0.
  - Then OP=12, start -> RLO=0, FLAGS=0x11.

Source files
------------

// File: rtl/alu_mc_if.sv
// Bus bundle for alu_mc: shared load bus, load/start strobes, output view
// select, and the data_out/busy/done response.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_in;
  logic             ld_a;
  logic             ld_b;
  logic             ld_op;
  logic             start;
  logic [1:0]       out_sel;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;

  modport master (
    output data_in, ld_a, ld_b, ld_op, start, out_sel,
    input  data_out, busy, done
  );

  modport slave (
    input  data_in, ld_a, ld_b, ld_op, start, out_sel,
    output data_out, busy, done
  );
endinterface

// File: rtl/alu_mc.sv
// Register-loaded ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add unsigned multiplier behind a busy/done handshake.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic    clk,
  input  logic    rst,
  alu_mc_if.slave bus
);
  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_NOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0]   CNT_ONE  = SHW'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  // Returns {E,V,C,N,Z, result}; anything not single-cycle reads as illegal.
  function automatic logic [WIDTH+4:0] alu_eval(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] res;
    logic [SHW-1:0]   sh;
    logic             e;
    logic             v;
    logic             c;
    wide = {(WIDTH+1){1'b0}};
    res  = ZERO_W;
    sh   = a[SHW-1:0];
    e    = 1'b0;
    v    = 1'b0;
    c    = 1'b0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOR: res = ~(a | b);
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        v    = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res = a - b;
        c   = (a < b);
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: res = b << sh;
      OP_SRL: res = b >> sh;
      OP_SRA: res = $unsigned($signed(b) >>> sh);
      default: e = 1'b1;
    endcase
    return {e, v, c, res[WIDTH-1], (res == ZERO_W), res};
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   rlo_q, rlo_d, rhi_q, rhi_d;
  logic [4:0]         flags_q, flags_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               done_q, done_d;
  logic [WIDTH+4:0]   eval_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [2*WIDTH-1:0] prod_step_s;

  // Next-state, register loads, single-cycle results and multiplier iteration.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rlo_d       = rlo_q;
    rhi_d       = rhi_q;
    flags_d     = flags_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    done_d      = 1'b0;
    eval_s      = alu_eval(op_q, a_q, b_q);
    // {hi, multiplier} shifts right one place per clock, adding the multiplicand into hi.
    mul_sum_s   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + ({1'b0, mcand_q} & {(WIDTH+1){prod_q[0]}});
    prod_step_s = {mul_sum_s, prod_q[WIDTH-1:1]};
    case (state_q)
      S_IDLE: begin
        a_d  = bus.ld_a  ? bus.data_in      : a_q;
        b_d  = bus.ld_b  ? bus.data_in      : b_q;
        op_d = bus.ld_op ? bus.data_in[3:0] : op_q;
        if (bus.start) begin
          if (op_q == OP_MUL) begin
            state_d = S_MUL;
            mcand_d = a_q;
            prod_d  = {ZERO_W, b_q};
            cnt_d   = {SHW{1'b0}};
          end else begin
            rlo_d   = eval_s[WIDTH-1:0];
            rhi_d   = ZERO_W;
            flags_d = eval_s[WIDTH+4:WIDTH];
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        prod_d = prod_step_s;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          rhi_d   = prod_step_s[2*WIDTH-1:WIDTH];
          rlo_d   = prod_step_s[WIDTH-1:0];
          flags_d = {1'b0, 1'b0, (prod_step_s[2*WIDTH-1:WIDTH] != ZERO_W), 1'b0,
                     (prod_step_s == {(2*WIDTH){1'b0}})};
          done_d  = 1'b1;
        end else begin
          state_d = S_MUL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= ZERO_W;
      b_q     <= ZERO_W;
      op_q    <= 4'd0;
      rlo_q   <= ZERO_W;
      rhi_q   <= ZERO_W;
      flags_q <= 5'd0;
      cnt_q   <= {SHW{1'b0}};
      mcand_q <= ZERO_W;
      prod_q  <= {(2*WIDTH){1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rlo_q   <= rlo_d;
      rhi_q   <= rhi_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  // Output view mux, fed only from registers.
  always_comb begin
    case (bus.out_sel)
      2'd0:    bus.data_out = rlo_q;
      2'd1:    bus.data_out = rhi_q;
      2'd2:    bus.data_out = {{(WIDTH-5){1'b0}}, flags_q};
      2'd3:    bus.data_out = {{(WIDTH-5){1'b0}}, (state_q == S_MUL), op_q};
      default: bus.data_out = ZERO_W;
    endcase
  end

  assign bus.busy = (state_q == S_MUL);
  assign bus.done = done_q;
endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vector table, randomized ops against
// an arithmetic reference model, and hand sequences for multiply/reset corners.
module tb_alu_mc;
  localparam int W = 32;

  typedef struct packed {
    logic [31:0] rlo;
    logic [31:0] rhi;
    logic [4:0]  flags;
  } res_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rlo;
    logic [31:0] rhi;
    logic [4:0]  flags;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs[16];

  alu_mc_if #(.WIDTH(W)) bus_if();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus_if.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flags are {E,V,C,N,Z}; overflow judged on true signed sums, not sign bits.
  function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t r;
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      4'd0: r.rlo = a & b;
      4'd1: r.rlo = a | b;
      4'd2: r.rlo = a ^ b;
      4'd3: r.rlo = ~(a | b);
      4'd4: begin
        p = 64'(a) + 64'(b);
        r.rlo = p[31:0];
        r.flags[2] = p[32];
        s = sa + sb;
        r.flags[3] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd5: begin
        r.rlo = a - b;
        r.flags[2] = (a < b);
        s = sa - sb;
        r.flags[3] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: r.rlo = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: r.rlo = b << a[4:0];
      4'd8: r.rlo = b >> a[4:0];
      4'd9: begin
        s = sb >>> a[4:0];
        r.rlo = s[31:0];
      end
      4'd10: begin
        p = 64'(a) * 64'(b);
        r.rlo = p[31:0];
        r.rhi = p[63:32];
        r.flags[2] = (p[63:32] != 32'd0);
        r.flags[0] = (p == 64'd0);
      end
      default: r.flags = 5'b10001;
    endcase
    if (op <= 4'd9) begin
      r.flags[1] = r.rlo[31];
      r.flags[0] = (r.rlo == 32'd0);
    end
    return r;
  endfunction

  task automatic load_reg(input int which, input logic [31:0] val);
    bus_if.data_in = val;
    bus_if.ld_a  = (which == 0);
    bus_if.ld_b  = (which == 1);
    bus_if.ld_op = (which == 2);
    @(posedge clk); #1;
    bus_if.ld_a  = 1'b0;
    bus_if.ld_b  = 1'b0;
    bus_if.ld_op = 1'b0;
  endtask

  task automatic fire();
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
  endtask

  // Called in the low clock phase; steps out_sel through the three result views.
  task automatic check_views(input string tag, input logic [31:0] rlo, input logic [31:0] rhi,
                             input logic [4:0] flags);
    bus_if.out_sel = 2'd0; #1;
    check({tag, ".rlo"}, bus_if.data_out, rlo);
    bus_if.out_sel = 2'd1; #1;
    check({tag, ".rhi"}, bus_if.data_out, rhi);
    bus_if.out_sel = 2'd2; #1;
    check({tag, ".flags"}, bus_if.data_out, {27'd0, flags});
    bus_if.out_sel = 2'd0;
  endtask

  // Fires start, waits (bounded) for done, checks timing, views and pulse width.
  task automatic fire_and_check(input string tag, input logic [3:0] op, input logic [31:0] rlo,
                                input logic [31:0] rhi, input logic [4:0] flags);
    int lat;
    int nbusy;
    fire();
    lat = 0;
    nbusy = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus_if.done) break;
      if (bus_if.busy) nbusy++;
    end
    check({tag, ".latency"}, lat, (op == 4'd10) ? 33 : 1);
    check({tag, ".busy_cycles"}, nbusy, (op == 4'd10) ? 32 : 0);
    check_views(tag, rlo, rhi, flags);
    @(negedge clk);
    check({tag, ".done_pulse"}, bus_if.done, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] rlo, input logic [31:0] rhi,
                        input logic [4:0] flags);
    load_reg(0, a);
    load_reg(1, b);
    load_reg(2, {28'd0, op});
    fire_and_check(tag, op, rlo, rhi, flags);
  endtask

  initial begin
    int lat;
    int nbusy;
    int ndone;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    res_t e;

    vecs[0]  = '{4'd0,  32'h0001FFFF, 32'h0001000F, 32'h0001000F, 32'h0, 5'h00};
    vecs[1]  = '{4'd4,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 5'h0A};
    vecs[2]  = '{4'd5,  32'h0001FFFF, 32'hFFF1000F, 32'h0010FFF0, 32'h0, 5'h04};
    vecs[3]  = '{4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 5'h00};
    vecs[4]  = '{4'd7,  32'h00000004, 32'hFFFFFFFF, 32'hFFFFFFF0, 32'h0, 5'h02};
    vecs[5]  = '{4'd8,  32'h00000004, 32'hFFFFFFFF, 32'h0FFFFFFF, 32'h0, 5'h00};
    vecs[6]  = '{4'd9,  32'h00000004, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 5'h02};
    vecs[7]  = '{4'd7,  32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 5'h02};
    vecs[8]  = '{4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 5'h04};
    vecs[9]  = '{4'd12, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h0, 5'h11};
    vecs[10] = '{4'd4,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 5'h05};
    vecs[11] = '{4'd10, 32'h00000000, 32'h00000005, 32'h00000000, 32'h0, 5'h01};
    vecs[12] = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 5'h00};
    vecs[13] = '{4'd3,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 5'h02};
    vecs[14] = '{4'd5,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 5'h08};
    vecs[15] = '{4'd1,  32'h000000F0, 32'h00000F00, 32'h00000FF0, 32'h0, 5'h00};

    rst = 1'b1;
    bus_if.data_in = 32'd0;
    bus_if.ld_a = 1'b0;
    bus_if.ld_b = 1'b0;
    bus_if.ld_op = 1'b0;
    bus_if.start = 1'b0;
    bus_if.out_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset.busy", bus_if.busy, 1'b0);
    check("reset.done", bus_if.done, 1'b0);
    check_views("reset", 32'd0, 32'd0, 5'd0);
    bus_if.out_sel = 2'd3; #1;
    check("reset.state_op", bus_if.data_out, 32'd0);
    bus_if.out_sel = 2'd0;

    for (int i = 0; i < 16; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].rlo, vecs[i].rhi, vecs[i].flags);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if (i % 5 == 0) op = 4'd10;
      e = model(op, a, b);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, e.rlo, e.rhi, e.flags);
    end

    // Multiply: start with a same-cycle ld_b, then ld_a and start while busy.
    load_reg(0, 32'hFFFFFFFF);
    load_reg(1, 32'hFFFFFFFF);
    load_reg(2, 32'd10);
    bus_if.data_in = 32'd2;
    bus_if.ld_b = 1'b1;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.ld_b = 1'b0;
    bus_if.start = 1'b0;
    lat = 0;
    nbusy = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus_if.done) break;
      if (bus_if.busy) nbusy++;
      if (lat == 3) begin
        bus_if.out_sel = 2'd3; #1;
        check("mul.state_view", bus_if.data_out, 32'h1A);
        bus_if.out_sel = 2'd0;
      end
      if (lat == 5) begin
        bus_if.data_in = 32'h12345678;
        bus_if.ld_a = 1'b1;
        bus_if.start = 1'b1;
      end else if (lat == 6) begin
        bus_if.ld_a = 1'b0;
        bus_if.start = 1'b0;
      end
    end
    check("mul.latency", lat, 33);
    check("mul.busy_cycles", nbusy, 32);
    check_views("mul", 32'h00000001, 32'hFFFFFFFE, 5'h04);
    // A must still be all-ones and B must now be 2: their sum wraps to 1 with carry.
    load_reg(2, 32'd4);
    fire_and_check("after_mul_add", 4'd4, 32'h00000001, 32'd0, 5'h04);

    // Reset during the tenth multiply cycle.
    load_reg(0, 32'hFFFFFFFF);
    load_reg(1, 32'hFFFFFFFF);
    load_reg(2, 32'd10);
    fire();
    repeat (10) @(negedge clk);
    check("rstmul.busy_before", bus_if.busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmul.busy", bus_if.busy, 1'b0);
    check("rstmul.done", bus_if.done, 1'b0);
    check_views("rstmul", 32'd0, 32'd0, 5'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.done) ndone++;
    end
    check("rstmul.no_done", ndone, 0);
    load_reg(2, 32'd12);
    fire_and_check("illegal12", 4'd12, 32'd0, 32'd0, 5'h11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
